// File: rtl/limbus_cpu_ocimem_ctrl.sv
// limbus_cpu_ocimem_ctrl: OCI debug RAM shared between JTAG monitor access and the CPU Avalon slave
module limbus_cpu_ocimem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              monitor_go,
  input  logic [ADDR_W:0]   avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  output logic              avs_waitrequest
);
  typedef enum logic [1:0] {J_IDLE, J_READ, J_LOAD} jrd_e;
  jrd_e              st_q, st_d;
  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] mon_a_q, mon_a_d, ram_addr;
  logic [31:0]       mon_d_q, mon_d_d, ram_rd_q, reg_rd_q, cpu_md;
  logic              ready_q, ready_d, error_q, error_d, go_q, go_d, rdv_q, sel_reg_q;
  logic              act_a, act_na, act_b, pulse, acc_rd, acc_wr, reg_sel, stat_wr;
  logic              unused_jdo;

  assign unused_jdo        = ^jdo[37:36];
  assign act_b             = take_action_ocimem_b;
  assign act_a             = take_action_ocimem_a && !act_b;
  assign act_na            = take_no_action_ocimem_a && !act_b && !take_action_ocimem_a;
  assign pulse             = take_action_ocimem_a || take_no_action_ocimem_a || take_action_ocimem_b;
  assign avs_waitrequest   = pulse || st_q == J_READ;
  assign acc_rd            = avs_read && !avs_waitrequest;
  assign acc_wr            = avs_write && !avs_waitrequest;
  assign reg_sel           = avs_address[ADDR_W];
  assign stat_wr           = acc_wr && reg_sel && avs_address[0] && avs_byteenable[0];
  assign ram_addr          = st_q == J_READ ? mon_a_q : avs_address[ADDR_W-1:0];
  assign MonDReg           = mon_d_q;
  assign monitor_ready     = ready_q;
  assign monitor_error     = error_q;
  assign monitor_go        = go_q;
  assign avs_readdatavalid = rdv_q;
  assign avs_readdata      = rdv_q ? (sel_reg_q ? reg_rd_q : ram_rd_q) : '0;

  // Single RAM port: JTAG write wins; the CPU only reaches the RAM when not stalled
  always_ff @(posedge clk) begin
    if (act_b) mem[mon_a_q] <= jdo[34:3];
    else if (acc_wr && !reg_sel)
      for (int i = 0; i < 4; i++)
        if (avs_byteenable[i]) mem[ram_addr][8*i +: 8] <= avs_writedata[8*i +: 8];
    ram_rd_q <= mem[ram_addr];
  end

  // JTAG read sequencing, address pointer, MonDReg and status next-state
  always_comb begin
    for (int i = 0; i < 4; i++)
      cpu_md[8*i +: 8] = avs_byteenable[i] ? avs_writedata[8*i +: 8] : mon_d_q[8*i +: 8];
    st_d    = (act_a || act_na) ? J_READ : (!act_b && st_q == J_READ) ? J_LOAD : J_IDLE;
    mon_a_d = (act_b || act_na) ? mon_a_q + 1'b1 : act_a ? jdo[ADDR_W+1:2] : mon_a_q;
    mon_d_d = act_b ? jdo[34:3] :
              (st_q == J_LOAD && !pulse) ? ram_rd_q :
              (acc_wr && reg_sel && !avs_address[0]) ? cpu_md : mon_d_q;
    ready_d = (ready_q && !(act_a && jdo[34])) || (stat_wr && avs_writedata[0]);
    error_d = (error_q && !(act_a && jdo[34])) || (stat_wr && avs_writedata[1]);
    go_d    = (go_q || (act_a && jdo[35])) && !(stat_wr && avs_writedata[2]);
  end

  // State registers; reset also drops any read in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q      <= J_IDLE;
      mon_a_q   <= '0;
      mon_d_q   <= '0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
      go_q      <= 1'b0;
      rdv_q     <= 1'b0;
      sel_reg_q <= 1'b0;
      reg_rd_q  <= '0;
    end else begin
      st_q      <= st_d;
      mon_a_q   <= mon_a_d;
      mon_d_q   <= mon_d_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
      go_q      <= go_d;
      rdv_q     <= acc_rd;
      sel_reg_q <= reg_sel;
      reg_rd_q  <= avs_address[0] ? {29'b0, go_q, error_q, ready_q} : mon_d_q;
    end
  end
endmodule
